// File: rtl/ddr3_app_arbiter_if.sv
// Handshake bundles around ddr3_app_arbiter.
//   ddr3_client_if : one memory-side client (request + read response).
//     master = client side, slave = arbiter side.
//     req_valid/req_ready : request handshake (ready is combinational)
//     req_write           : 1 = write, 0 = read
//     req_addr/data/be    : 27-bit app address, 256-bit data, 32 byte enables
//     resp_valid/data     : single-cycle read return, no backpressure
//   ddr3_app_if : ddr3_wrapper app_* user interface.
//     master = arbiter side, slave = wrapper side.
interface ddr3_client_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [26:0]  req_addr;
  logic [255:0] req_data;
  logic [31:0]  req_be;
  logic         resp_valid;
  logic [255:0] resp_data;

  modport master (output req_valid, req_write, req_addr, req_data, req_be,
                  input  req_ready, resp_valid, resp_data);
  modport slave  (input  req_valid, req_write, req_addr, req_data, req_be,
                  output req_ready, resp_valid, resp_data);
endinterface

interface ddr3_app_if;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [255:0] app_wdf_data;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;

  modport master (output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
                         app_wdf_wren, app_wdf_end,
                  input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid);
  modport slave  (input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
                         app_wdf_wren, app_wdf_end,
                  output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid);
endinterface

// File: rtl/ddr3_app_arbiter.sv
// Two-client round-robin arbiter / sequencer for the DDR3 app_* interface.
// One request is granted at a time (IDLE), then its single-beat command and
// write data are driven until accepted (ISSUE). The issuing client of every
// read is queued in an in-order tag FIFO so returned data is routed back.
// Ports:
//   i_ui_clk              : clock, rising edge
//   i_ui_clk_sync_rst     : synchronous active-high reset
//   i_init_calib_complete : grants blocked while low
//   c0, c1                : client bundles (slave side)
//   app                   : wrapper app_* bundle (master side)
//   o_tag_err             : sticky, read data returned with no read outstanding
module ddr3_app_arbiter #(
  parameter int TAG_DEPTH = 32
) (
  input  logic           i_ui_clk,
  input  logic           i_ui_clk_sync_rst,
  input  logic           i_init_calib_complete,
  ddr3_client_if.slave   c0,
  ddr3_client_if.slave   c1,
  ddr3_app_if.master     app,
  output logic           o_tag_err
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] TAG_FULL = (AW+1)'(TAG_DEPTH);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  state_t r_state, w_state_nxt;

  logic                   r_last_grant;
  logic                   r_client;
  logic                   r_rd;
  logic [26:0]            r_addr;
  logic [255:0]           r_data;
  logic [31:0]            r_mask;
  logic                   r_cmd_done;
  logic                   r_dat_done;
  logic                   r_tag_err;

  logic [TAG_DEPTH-1:0]   r_tag_mem;
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_tag_cnt;

  logic [1:0]             r_resp_vld;
  logic [1:0][255:0]      r_resp_data;

  logic [1:0]             w_vld, w_wr, w_elig, w_ready;
  logic                   w_room, w_win, w_grant;
  logic                   w_app_en, w_wren;
  logic                   w_sel_wr;
  logic [26:0]            w_sel_addr;
  logic [255:0]           w_sel_data;
  logic [31:0]            w_sel_be;
  logic                   w_push, w_pop, w_err, w_pop_id;

  assign w_vld  = {c1.req_valid, c0.req_valid};
  assign w_wr   = {c1.req_write, c0.req_write};
  assign w_room = (r_tag_cnt < TAG_FULL);
  // Writes never consume a tag, so a full FIFO only blocks reads.
  assign w_elig = w_vld & {2{i_init_calib_complete}} & (w_wr | {2{w_room}});
  // On a tie the client that did not win last time goes.
  assign w_win  = (&w_elig) ? ~r_last_grant : w_elig[1];

  assign w_sel_wr   = w_win ? c1.req_write : c0.req_write;
  assign w_sel_addr = w_win ? c1.req_addr  : c0.req_addr;
  assign w_sel_data = w_win ? c1.req_data  : c0.req_data;
  assign w_sel_be   = w_win ? c1.req_be    : c0.req_be;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_ready     = 2'b00;
    w_app_en    = 1'b0;
    w_wren      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so ready stays low while reset is held.
        if ((|w_elig) && !i_ui_clk_sync_rst) begin
          w_grant        = 1'b1;
          w_ready[w_win] = 1'b1;
          w_state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_app_en = ~r_cmd_done;
        w_wren   = ~r_dat_done;
        // Leave once both halves are accepted, counting this cycle's accepts.
        if ((r_cmd_done | app.app_rdy) && (r_dat_done | app.app_wdf_rdy))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_ui_clk) begin
    if (i_ui_clk_sync_rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_client     <= 1'b0;
      r_rd         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_mask       <= '0;
      r_cmd_done   <= 1'b0;
      r_dat_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last_grant <= w_win;
        r_client     <= w_win;
        r_rd         <= ~w_sel_wr;
        r_addr       <= w_sel_addr;
        r_data       <= w_sel_data;
        r_mask       <= ~w_sel_be;
        r_cmd_done   <= 1'b0;
        // A read has no data phase.
        r_dat_done   <= ~w_sel_wr;
      end else begin
        if (w_app_en & app.app_rdy)   r_cmd_done <= 1'b1;
        if (w_wren & app.app_wdf_rdy) r_dat_done <= 1'b1;
      end
    end
  end

  assign app.app_en       = w_app_en;
  assign app.app_addr     = r_addr;
  assign app.app_cmd      = {2'b00, r_rd};
  assign app.app_wdf_wren = w_wren;
  assign app.app_wdf_end  = w_wren;
  assign app.app_wdf_data = r_data;
  assign app.app_wdf_mask = r_mask;

  assign c0.req_ready = w_ready[0];
  assign c1.req_ready = w_ready[1];

  // Tag FIFO: one bit per outstanding read holding the issuing client.
  assign w_push   = w_app_en & app.app_rdy & r_rd;
  assign w_pop    = app.app_rd_data_valid & (r_tag_cnt != '0);
  assign w_err    = app.app_rd_data_valid & (r_tag_cnt == '0);
  assign w_pop_id = r_tag_mem[r_rptr];

  always_ff @(posedge i_ui_clk) begin
    if (w_push) r_tag_mem[r_wptr] <= r_client;
  end

  always_ff @(posedge i_ui_clk) begin
    if (i_ui_clk_sync_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_tag_cnt <= '0;
      r_tag_err <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_tag_cnt <= r_tag_cnt + (AW+1)'(1);
        2'b01:   r_tag_cnt <= r_tag_cnt - (AW+1)'(1);
        default: r_tag_cnt <= r_tag_cnt;
      endcase
      if (w_err) r_tag_err <= 1'b1;
    end
  end

  always_ff @(posedge i_ui_clk) begin
    if (i_ui_clk_sync_rst) begin
      r_resp_vld  <= '0;
      r_resp_data <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        r_resp_vld[n] <= w_pop && (w_pop_id == n[0]);
        if (w_pop && (w_pop_id == n[0])) r_resp_data[n] <= app.app_rd_data;
      end
    end
  end

  assign c0.resp_valid = r_resp_vld[0];
  assign c0.resp_data  = r_resp_data[0];
  assign c1.resp_valid = r_resp_vld[1];
  assign c1.resp_data  = r_resp_data[1];
  assign o_tag_err     = r_tag_err;
endmodule

// File: tb/tb_ddr3_app_arbiter.sv
module tb_ddr3_app_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic calib = 1'b0;
  logic tag_err;
  int   n_chk = 0;
  int   n_bad = 0;

  ddr3_client_if c0_if ();
  ddr3_client_if c1_if ();
  ddr3_app_if    app_if ();

  ddr3_app_arbiter #(.TAG_DEPTH(32)) dut (
    .i_ui_clk              (clk),
    .i_ui_clk_sync_rst     (rst),
    .i_init_calib_complete (calib),
    .c0                    (c0_if),
    .c1                    (c1_if),
    .app                   (app_if),
    .o_tag_err             (tag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 3ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    c0_if.req_valid = 0; c0_if.req_write = 0; c0_if.req_addr = '0;
    c0_if.req_data  = '0; c0_if.req_be = '1;
    c1_if.req_valid = 0; c1_if.req_write = 0; c1_if.req_addr = '0;
    c1_if.req_data  = '0; c1_if.req_be = '1;
    app_if.app_rdy = 1; app_if.app_wdf_rdy = 1;
    app_if.app_rd_data = '0; app_if.app_rd_data_valid = 0;
  endtask

  task automatic do_reset;
    rst = 1; idle_inputs(); calib = 1;
    tick; tick;
    rst = 0;
  endtask

  logic [255:0] dv;
  logic [255:0] dw;

  initial begin
    // ---- reset state
    idle_inputs(); calib = 1; rst = 1;
    tick; tick; settle;
    chk("rst_en",   app_if.app_en, 0);
    chk("rst_wren", app_if.app_wdf_wren, 0);
    chk("rst_cmd",  app_if.app_cmd, 0);
    chk("rst_err",  tag_err, 0);
    chk("rst_rv0",  c0_if.resp_valid, 0);
    rst = 0;

    // ---- single write
    dw = {8{32'hDEADBEEF}};
    tick; c0_if.req_valid = 1; c0_if.req_write = 1; c0_if.req_addr = 27'h100;
    c0_if.req_data = dw; c0_if.req_be = '1; settle;
    chk("w_rdy0", c0_if.req_ready, 1);
    chk("w_rdy1", c1_if.req_ready, 0);
    tick; c0_if.req_valid = 0; settle;
    chk("w_en",   app_if.app_en, 1);
    chk("w_wren", app_if.app_wdf_wren, 1);
    chk("w_end",  app_if.app_wdf_end, 1);
    chk("w_cmd",  app_if.app_cmd, 3'b000);
    chk("w_mask", app_if.app_wdf_mask, 0);
    chk("w_addr", app_if.app_addr, 27'h100);
    chk("w_data", app_if.app_wdf_data, dw);
    chk("w_rdy_iss", c0_if.req_ready, 0);
    tick; c0_if.req_valid = 1; c0_if.req_be = 32'h0000FFFF; settle;
    chk("w_idle_en", app_if.app_en, 0);
    chk("w_idle_rdy", c0_if.req_ready, 1);
    tick; c0_if.req_valid = 0; settle;
    chk("w_mask2", app_if.app_wdf_mask, 32'hFFFF0000);

    // ---- contention: both clients hold reads
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick;
      c0_if.req_valid = 1; c0_if.req_write = 0; c0_if.req_addr = 27'h10;
      c1_if.req_valid = 1; c1_if.req_write = 0; c1_if.req_addr = 27'h20;
      settle;
      chk($sformatf("ct_rdy0_%0d", k), c0_if.req_ready, (k % 2) == 0);
      chk($sformatf("ct_rdy1_%0d", k), c1_if.req_ready, (k % 2) == 1);
      tick; settle;
      chk($sformatf("ct_addr_%0d", k), app_if.app_addr, (k % 2) ? 27'h20 : 27'h10);
      chk($sformatf("ct_cmd_%0d", k), app_if.app_cmd, 3'b001);
    end
    c0_if.req_valid = 0; c1_if.req_valid = 0;
    for (int j = 0; j <= 4; j++) begin
      tick;
      if (j < 4) begin
        app_if.app_rd_data_valid = 1;
        app_if.app_rd_data = {32{8'(8'h30 + j)}};
      end else begin
        app_if.app_rd_data_valid = 0;
      end
      settle;
      if (j == 0) begin
        chk("rr_early0", c0_if.resp_valid, 0);
        chk("rr_early1", c1_if.resp_valid, 0);
      end else begin
        dv = {32{8'(8'h30 + j - 1)}};
        chk($sformatf("rr_v0_%0d", j-1), c0_if.resp_valid, ((j-1) % 2) == 0);
        chk($sformatf("rr_v1_%0d", j-1), c1_if.resp_valid, ((j-1) % 2) == 1);
        if (((j-1) % 2) == 0) chk($sformatf("rr_d_%0d", j-1), c0_if.resp_data, dv);
        else                  chk($sformatf("rr_d_%0d", j-1), c1_if.resp_data, dv);
      end
    end

    // ---- split handshake: command first, data late
    do_reset();
    app_if.app_wdf_rdy = 0;
    tick; c0_if.req_valid = 1; c0_if.req_write = 1; c0_if.req_addr = 27'h200; settle;
    chk("sp_rdy", c0_if.req_ready, 1);
    tick; c0_if.req_valid = 0; settle;
    chk("sp_en1", app_if.app_en, 1);
    chk("sp_wr1", app_if.app_wdf_wren, 1);
    for (int t = 2; t <= 4; t++) begin
      tick; if (t == 4) app_if.app_wdf_rdy = 1; settle;
      chk($sformatf("sp_en%0d", t), app_if.app_en, 0);
      chk($sformatf("sp_wr%0d", t), app_if.app_wdf_wren, 1);
    end
    tick; c1_if.req_valid = 1; c1_if.req_write = 0; c1_if.req_addr = 27'h300; settle;
    chk("sp_wr5", app_if.app_wdf_wren, 0);
    chk("sp_rdy5", c1_if.req_ready, 1);
    tick; c1_if.req_valid = 0; settle;
    chk("sp_rd_en", app_if.app_en, 1);
    chk("sp_rd_wr", app_if.app_wdf_wren, 0);
    // data first, command late
    tick; c0_if.req_valid = 1; c0_if.req_addr = 27'h240; settle;
    chk("df_rdy", c0_if.req_ready, 1);
    tick; c0_if.req_valid = 0; app_if.app_rdy = 0; settle;
    chk("df_en1", app_if.app_en, 1);
    chk("df_wr1", app_if.app_wdf_wren, 1);
    tick; settle;
    chk("df_en2", app_if.app_en, 1);
    chk("df_wr2", app_if.app_wdf_wren, 0);
    tick; app_if.app_rdy = 1; settle;
    chk("df_en3", app_if.app_en, 1);
    tick; c1_if.req_valid = 1; settle;
    chk("df_en4", app_if.app_en, 0);
    chk("df_rdy4", c1_if.req_ready, 1);
    tick; c1_if.req_valid = 0;

    // ---- tag FIFO full
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tick; c0_if.req_valid = 1; c0_if.req_write = 0; settle;
      chk($sformatf("tf_rdy_%0d", i), c0_if.req_ready, 1);
      tick; settle;
      chk($sformatf("tf_en_%0d", i), app_if.app_en, 1);
    end
    tick; c1_if.req_valid = 1; c1_if.req_write = 1; settle;
    chk("tf_full_rd", c0_if.req_ready, 0);
    chk("tf_full_wr", c1_if.req_ready, 1);
    tick; c1_if.req_valid = 0; settle;
    chk("tf_wr_wren", app_if.app_wdf_wren, 1);
    tick; app_if.app_rd_data_valid = 1; app_if.app_rd_data = {8{32'h11112222}}; settle;
    chk("tf_still_full", c0_if.req_ready, 0);
    tick; app_if.app_rd_data_valid = 0; settle;
    chk("tf_after_pop", c0_if.req_ready, 1);
    chk("tf_rv_a", c0_if.resp_valid, 1);
    tick; app_if.app_rd_data_valid = 1; settle;
    chk("tf_pushpop_en", app_if.app_en, 1);
    tick; app_if.app_rd_data_valid = 0; settle;
    chk("tf_cnt31_rdy", c0_if.req_ready, 1);
    chk("tf_rv_b", c0_if.resp_valid, 1);
    tick; settle;
    tick; settle;
    chk("tf_full_again", c0_if.req_ready, 0);
    c0_if.req_valid = 0;

    // ---- calibration gate and empty-FIFO error
    do_reset();
    calib = 0;
    for (int i = 0; i < 3; i++) begin
      tick; c0_if.req_valid = 1; c1_if.req_valid = 1; c1_if.req_write = 1; settle;
      chk($sformatf("cal_rdy0_%0d", i), c0_if.req_ready, 0);
      chk($sformatf("cal_rdy1_%0d", i), c1_if.req_ready, 0);
      chk($sformatf("cal_en_%0d", i), app_if.app_en, 0);
    end
    tick; app_if.app_rd_data_valid = 1; settle;
    chk("err_pre", tag_err, 0);
    tick; app_if.app_rd_data_valid = 0; settle;
    chk("err_set", tag_err, 1);
    chk("err_rv0", c0_if.resp_valid, 0);
    chk("err_rv1", c1_if.resp_valid, 0);
    tick; calib = 1; settle;
    chk("err_sticky", tag_err, 1);
    chk("cal_tie0", c0_if.req_ready, 1);
    tick; c0_if.req_valid = 0; c1_if.req_valid = 0;

    // ---- reset during ISSUE
    do_reset();
    tick; c1_if.req_valid = 1; c1_if.req_write = 0; c1_if.req_addr = 27'h40; settle;
    chk("mr_rdy1", c1_if.req_ready, 1);
    tick; c1_if.req_valid = 0; settle;
    chk("mr_rd_en", app_if.app_en, 1);
    tick; c0_if.req_valid = 1; c0_if.req_write = 1; c0_if.req_addr = 27'h80;
    c0_if.req_be = 32'h0000000F; app_if.app_rdy = 0; app_if.app_wdf_rdy = 0; settle;
    chk("mr_rdy0", c0_if.req_ready, 1);
    tick; c1_if.req_valid = 1; settle;
    chk("mr_stall", app_if.app_en, 1);
    tick; rst = 1; settle;
    chk("mr_pre_en", app_if.app_en, 1);
    tick; settle;
    chk("mr_en",   app_if.app_en, 0);
    chk("mr_wren", app_if.app_wdf_wren, 0);
    chk("mr_end",  app_if.app_wdf_end, 0);
    chk("mr_r0",   c0_if.req_ready, 0);
    chk("mr_r1",   c1_if.req_ready, 0);
    chk("mr_cmd",  app_if.app_cmd, 0);
    chk("mr_addr", app_if.app_addr, 0);
    chk("mr_mask", app_if.app_wdf_mask, 0);
    chk("mr_wdat", app_if.app_wdf_data, 0);
    chk("mr_rv",   {c1_if.resp_valid, c0_if.resp_valid}, 0);
    chk("mr_rd",   c1_if.resp_data, 0);
    chk("mr_err",  tag_err, 0);
    rst = 0; c0_if.req_valid = 0; c1_if.req_valid = 0;
    app_if.app_rdy = 1; app_if.app_wdf_rdy = 1;
    tick; app_if.app_rd_data_valid = 1; settle;
    tick; app_if.app_rd_data_valid = 0;
    c0_if.req_valid = 1; c0_if.req_write = 0;
    c1_if.req_valid = 1; c1_if.req_write = 0; settle;
    chk("mr_cnt0", tag_err, 1);
    chk("mr_rv1_none", c1_if.resp_valid, 0);
    chk("mr_first0", c0_if.req_ready, 1);
    chk("mr_first1", c1_if.req_ready, 0);
    tick; c0_if.req_valid = 0; c1_if.req_valid = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/ddr3_app_arbiter.md
# ddr3_app_arbiter

- Two-client arbiter and sequencer for the DDR3 controller user interface (`ddr3_wrapper` app_* ports), running in the `ui_clk` domain.
- Grants one client request at a time by round-robin and drives the single-beat app command and write-data handshakes.
- Records the issuing client of every read in an in-order tag FIFO and routes returned read data back to that client.
- Sits between the memory-side clients (e.g. cache refill and DMA) and `ddr3_wrapper`.

## Interface
Parameters:
- TAG_DEPTH, 32, maximum outstanding reads (power of two).

Ports:
- ui_clk  in  1  clock; all logic on rising edge.
- ui_clk_sync_rst  in  1  synchronous, active-high reset.
- init_calib_complete  in  1  no grants while low.
- cN_req_valid  in  1  client N request (N = 0, 1).
- cN_req_ready  out  1  request accepted this cycle (combinational).
- cN_req_write  in  1  1 = write, 0 = read.
- cN_req_addr  in  27  app address (8-byte units).
- cN_req_data  in  256  write data.
- cN_req_be  in  32  byte enables, active-high.
- cN_resp_valid  out  1  read data valid for one cycle; no backpressure.
- cN_resp_data  out  256  read data.
- app_addr  out  27  to wrapper.
- app_cmd  out  3  000 = write, 001 = read.
- app_en  out  1  command strobe.
- app_rdy  in  1  command accept.
- app_wdf_data  out  256  write data.
- app_wdf_mask  out  32  equals ~be; 1 = byte masked.
- app_wdf_wren  out  1  write-data strobe.
- app_wdf_end  out  1  equals app_wdf_wren (single beat).
- app_wdf_rdy  in  1  write-data accept.
- app_rd_data  in  256  read data.
- app_rd_data_valid  in  1  read data strobe.
- tag_err  out  1  sticky: read data arrived with the tag FIFO empty.

## Operation
FSM states are IDLE and ISSUE.

IDLE:
- A client is eligible if cN_req_valid=1 and init_calib_complete=1.
- A read additionally requires tag_count < TAG_DEPTH. A write is eligible even when the tag FIFO is full.
- Winner selection:
  - If only one client is eligible, it wins.
  - If both are eligible, the client other than last_grant wins. last_grant resets to 1, so client 0 wins the first tie.
- For the winner, assert cN_req_ready in the same cycle. Latch write flag, address, data and ~be; update last_grant; go to ISSUE.

ISSUE:
- Drive app_en=1 with the latched address and cmd until the first cycle with app_rdy=1 (cmd_done).
- For a write, also drive app_wdf_wren=app_wdf_end=1 until the first cycle with app_wdf_rdy=1 (data_done). Command and data may be accepted in either order or in the same cycle.
- Each strobe deasserts in the cycle after its own acceptance.
- For a read, data_done is treated as already set.
- Go to IDLE in the cycle after both cmd_done and data_done are satisfied, counting the acceptance cycle itself.
- On read command acceptance (app_en & app_rdy), push the client ID into the tag FIFO.

Read return:
- On app_rd_data_valid, pop the tag FIFO.
- Register app_rd_data to cN_resp_data and pulse cN_resp_valid for the popped client.
- If the FIFO is empty on app_rd_data_valid: set tag_err, emit no response, leave the FIFO unchanged.
- tag_count is a (log2(TAG_DEPTH)+1)-bit counter.
  - A simultaneous push and pop leaves it unchanged.
  - Read and write pointers wrap modulo TAG_DEPTH.

Reset (synchronous):
- State returns to IDLE, last_grant=1, tag_count=0, pointers=0, tag_err=0.
- All outputs become 0, including app_en, app_wdf_wren, cN_req_ready, cN_resp_valid and resp_data.
- A transaction in progress is abandoned. The tag FIFO is cleared; the wrapper is reset by the same reset.

## Timing
- Grant-to-app_en latency: 1 cycle; app_en rises the cycle after cN_req_ready.
- Minimum request period: 2 cycles (IDLE + ISSUE) when app_rdy and app_wdf_rdy are high.
- Read return latency: cN_resp_valid is asserted exactly 1 cycle after app_rd_data_valid.
- Read responses return in command order.
- cN_req_ready is never high for both clients in the same cycle, and never high outside IDLE.

## Test plan
- Single write: c0 write at addr 0x100, be=0xFFFFFFFF, with rdy signals high.
  - Required: ready in cycle t; app_en=app_wdf_wren=1, cmd=000, mask=0 in t+1; back in IDLE at t+2.
- Contention: both clients hold reads from reset.
  - Required: grant order is 0,1,0,1.
  - Required: returned data D0..D3 appear on c0, c1, c0, c1 respectively, each 1 cycle after app_rd_data_valid.
- Split handshake: write with app_rdy high at t+1 but app_wdf_rdy low until t+4.
  - Required: app_en for 1 cycle only; app_wdf_wren held t+1..t+4; next grant at t+5.
  - Also: data accepted before command.
- Tag full: 32 reads issued with no returns.
  - Required: the 33rd read is not granted; a write from the other client is still granted.
  - Required: after one app_rd_data_valid, the read is granted.
  - Also: simultaneous push/pop at count=31 leaves count 31.
- Calibration and error: with init_calib_complete=0, no ready.
  - Required: app_rd_data_valid with an empty FIFO sets tag_err and produces no cN_resp_valid.
- Mid-operation reset: assert reset during ISSUE with app_rdy=0.
  - Required: next cycle all outputs are 0 and tag_count=0; the first grant after reset goes to client 0.
